// File: rtl/qr_result_collector.sv
// ---------------------------------------------------------------------------
// qr_result_collector
//
// Receiving end of the QR_CORDIC output bus. A burst of ROWS consecutive rows
// (COLS signed W-bit elements each) is captured into an internal row store
// and then drained one element per accepted handshake over a valid/ready
// interface.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   in_valid      QR_CORDIC out_valid, high in the cycle row 0 is presented
//   in_row        QR_CORDIC row bus, element j at [W*j+W-1 : W*j]
//   elem_valid    element available on elem_data / elem_idx
//   elem_ready    downstream accept (handshake = elem_valid & elem_ready)
//   elem_data     current element (bit-exact copy of the captured value)
//   elem_idx      COLS*row + col of the current element
//   busy          high while capturing or draining
//   done          one-cycle pulse after the last element is accepted
//   overflow      sticky: a burst arrived while a drain was in progress
//
// Optional feature (macro QR_COLLECT_LATCNT_EN):
//   start         clears and arms the latency counter
//   lat_cnt       cycles from start to burst arrival, saturating at 511
// ---------------------------------------------------------------------------
module qr_result_collector #(
    parameter int W    = 13,
    parameter int COLS = 4,
    parameter int ROWS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [W*COLS-1:0] in_row,
    output logic              elem_valid,
    input  logic              elem_ready,
    output logic [W-1:0]      elem_data,
    output logic [4:0]        elem_idx,
    output logic              busy,
    output logic              done,
    output logic              overflow
`ifdef QR_COLLECT_LATCNT_EN
    ,
    input  logic              start,
    output logic [8:0]        lat_cnt
`endif
);

    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int LAST_IDX = ROWS * COLS - 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;

    logic [W*COLS-1:0] row_buf [ROWS];

    logic [1:0]       state_reg;
    logic [ROW_W-1:0] row_cnt_reg;
    logic [4:0]       idx_reg;
    logic             elem_valid_reg;
    logic [W-1:0]     elem_data_reg;
    logic             done_reg;
    logic             overflow_reg;

    // ---------------- row store write port ----------------
    // Row 0 is written on the triggering edge in IDLE; CAPTURE then writes
    // every cycle unconditionally, so the burst is exactly ROWS cycles long.
    logic             wr_en;
    logic [ROW_W-1:0] wr_row;

    assign wr_en  = ((state_reg == S_IDLE) && in_valid) || (state_reg == S_CAPTURE);
    assign wr_row = (state_reg == S_CAPTURE) ? row_cnt_reg : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            row_buf[wr_row] <= in_row;
        end
    end

    // ---------------- row store read port ----------------
    // The address is the element that will be shown next: 0 when entering
    // DRAIN, idx+1 on an accepted handshake. The result lands in
    // elem_data_reg, so the read is registered.
    logic [4:0]        rd_idx_next;
    logic [ROW_W-1:0]  rd_row;
    logic [COL_W-1:0]  rd_col;
    logic [W*COLS-1:0] rd_word;
    logic [W-1:0]      rd_elems [COLS];
    logic [W-1:0]      rd_elem;

    always_comb begin
        rd_idx_next = 5'd0;
        if (state_reg == S_DRAIN) begin
            rd_idx_next = idx_reg + 5'd1;
        end
    end

    assign rd_row  = ROW_W'(rd_idx_next / COLS);
    assign rd_col  = COL_W'(rd_idx_next % COLS);
    assign rd_word = row_buf[rd_row];

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            assign rd_elems[gi] = rd_word[W*gi +: W];
        end
    endgenerate

    assign rd_elem = rd_elems[rd_col];

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            row_cnt_reg    <= '0;
            idx_reg        <= 5'd0;
            elem_valid_reg <= 1'b0;
            elem_data_reg  <= '0;
            done_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        state_reg   <= S_CAPTURE;
                        row_cnt_reg <= ROW_W'(1);
                    end
                end
                S_CAPTURE: begin
                    if (row_cnt_reg == ROW_W'(ROWS - 1)) begin
                        state_reg      <= S_DRAIN;
                        row_cnt_reg    <= '0;
                        idx_reg        <= 5'd0;
                        elem_valid_reg <= 1'b1;
                        elem_data_reg  <= rd_elem;
                    end else begin
                        row_cnt_reg <= row_cnt_reg + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // A new burst cannot be stored mid-drain: flag and drop it.
                    if (in_valid) begin
                        overflow_reg <= 1'b1;
                    end
                    if (elem_ready) begin
                        if (idx_reg == 5'(LAST_IDX)) begin
                            elem_valid_reg <= 1'b0;
                            done_reg       <= 1'b1;
                            state_reg      <= S_IDLE;
                        end else begin
                            idx_reg       <= idx_reg + 5'd1;
                            elem_data_reg <= rd_elem;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign elem_valid = elem_valid_reg;
    assign elem_data  = elem_data_reg;
    assign elem_idx   = idx_reg;
    assign busy       = (state_reg != S_IDLE);
    assign done       = done_reg;
    assign overflow   = overflow_reg;

`ifdef QR_COLLECT_LATCNT_EN
    // ---------------- start-to-burst latency counter ----------------
    // The arrival edge itself is counted, so a burst N cycles after start
    // reads N; start together with the trigger reads 0.
    logic       trigger;
    logic       armed_reg;
    logic [8:0] lat_cnt_reg;

    assign trigger = (state_reg == S_IDLE) && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_reg   <= 1'b0;
            lat_cnt_reg <= 9'd0;
        end else if (start) begin
            lat_cnt_reg <= 9'd0;
            armed_reg   <= !trigger;
        end else if (armed_reg) begin
            if (lat_cnt_reg != 9'd511) begin
                lat_cnt_reg <= lat_cnt_reg + 9'd1;
            end
            if (trigger) begin
                armed_reg <= 1'b0;
            end
        end
    end

    assign lat_cnt = lat_cnt_reg;
`endif

endmodule

// File: tb/tb_qr_result_collector.sv
// ---------------------------------------------------------------------------
// tb_qr_result_collector
//
// Bursts are described in a table and applied in a loop. Every captured
// element is pushed to a scoreboard queue as its row is driven; each cycle the
// DUT shows a valid element it is compared with the queue head, and the head
// is popped on an accepted handshake. Inputs change and outputs are sampled on
// the falling edge. Cycle k of a burst is counted from the in_valid cycle
// (k = 0); the first element is expected at k = ROWS and, with elem_ready held
// high, done at k = ROWS + ROWS*COLS (the 41st cycle of the burst).
// ---------------------------------------------------------------------------
module tb_qr_result_collector;

    localparam int W    = 13;
    localparam int COLS = 4;
    localparam int ROWS = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [W*COLS-1:0] in_row;
    logic              elem_valid;
    logic              elem_ready;
    logic [W-1:0]      elem_data;
    logic [4:0]        elem_idx;
    logic              busy;
    logic              done;
    logic              overflow;
`ifdef QR_COLLECT_LATCNT_EN
    logic              start;
    logic [8:0]        lat_cnt;
`endif

    always #5 clk = ~clk;

    qr_result_collector #(.W(W), .COLS(COLS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_row     (in_row),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .elem_data  (elem_data),
        .elem_idx   (elem_idx),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
`ifdef QR_COLLECT_LATCNT_EN
        ,
        .start      (start),
        .lat_cnt    (lat_cnt)
`endif
    );

    typedef struct {
        logic [4:0]   idx;
        logic [W-1:0] data;
    } exp_t;

    // mode: 0 = 16*r+j, 1 = -1/-4096 alternating, 2 = random
    // rdy : 0 = always ready, 1 = ready pattern 1,0,0,1
    // exp_lat / ovf_idx / rst_idx: -1 = not used
    // imm : start in the current (done) cycle instead of the next one
    typedef struct {
        int mode;
        int rdy;
        int exp_lat;
        int ovf_idx;
        int rst_idx;
        int exp_ovf;
        int imm;
        int idle;
    } vec_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    task automatic check_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle", {busy, elem_valid, done}, 3'b000);
        end
    endtask

    task automatic run_burst(input int id, input vec_t v);
        exp_t         e;
        logic [W-1:0] val;
        bit           pulsed = 0;
        bit           rdy;
        if (v.imm == 0) @(negedge clk);
        for (int k = 0; k < 400; k++) begin
            if (k > 0) @(negedge clk);
            in_valid = (k == 0);
`ifdef QR_COLLECT_LATCNT_EN
            if (k > 0) start = 1'b0;
`endif
            if (k < ROWS) begin
                for (int j = 0; j < COLS; j++) begin
                    case (v.mode)
                        0:       val = W'(16 * k + j);
                        1:       val = (((k + j) % 2) != 0) ? 13'h1000 : 13'h1FFF;
                        default: val = W'($urandom);
                    endcase
                    in_row[W*j +: W] = val;
                    e.idx  = 5'(COLS * k + j);
                    e.data = val;
                    exp_q.push_back(e);
                end
                elem_ready = 1'b0;
                if (k == ROWS - 1) chk("capture_busy", {busy, elem_valid}, 2'b10);
            end else begin
                in_row = (W*COLS)'({$urandom(), $urandom()});
                rdy = (v.rdy == 0) || (((k - ROWS) % 4) == 0) || (((k - ROWS) % 4) == 3);
                elem_ready = rdy;
                if (k == ROWS) chk("first_valid", elem_valid, 1);
                if (elem_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_elem", 1, 0);
                    end else begin
                        chk("elem", {elem_idx, elem_data}, {exp_q[0].idx, exp_q[0].data});
                        if (v.rst_idx >= 0 && int'(exp_q[0].idx) == v.rst_idx) begin
                            rst = 1'b1;
                            #1;
                            chk("reset_mid_drain",
                                {elem_valid, busy, done, overflow, elem_idx, elem_data}, 0);
                            @(negedge clk);
                            rst        = 1'b0;
                            in_valid   = 1'b0;
                            elem_ready = 1'b0;
                            exp_q.delete();
                            $display("burst %0d: reset at idx %0d", id, v.rst_idx);
                            return;
                        end
                        if (v.ovf_idx >= 0 && !pulsed && int'(exp_q[0].idx) == v.ovf_idx) begin
                            in_valid = 1'b1;
                            pulsed   = 1;
                        end
                        if (rdy) void'(exp_q.pop_front());
                    end
                end
                if (done) begin
                    if (v.exp_lat >= 0) chk("done_cycle", k, v.exp_lat);
                    chk("done_valid_low", elem_valid, 0);
                    chk("all_drained", exp_q.size(), 0);
                    chk("overflow", overflow, v.exp_ovf);
                    $display("burst %0d: mode=%0d rdy=%0d done at cycle %0d overflow=%b",
                             id, v.mode, v.rdy, k, overflow);
                    return;
                end
            end
        end
        chk("timeout", 0, 1);
        in_valid = 1'b0;
        exp_q.delete();
    endtask

    vec_t vecs[8];
`ifdef QR_COLLECT_LATCNT_EN
    vec_t lv;
`endif

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        elem_ready = 1'b0;
        in_row     = '0;
`ifdef QR_COLLECT_LATCNT_EN
        start      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_state", {elem_valid, busy, done, overflow, elem_idx, elem_data}, 0);
`ifdef QR_COLLECT_LATCNT_EN
        chk("reset_lat", lat_cnt, 0);
`endif
        rst = 1'b0;

        //          mode rdy lat ovf rst eovf imm idle
        vecs[0] = '{0,   0,  40, -1, -1, 0,   0,  1};   // incrementing data
        vecs[1] = '{0,   1,  -1, -1, -1, 0,   0,  1};   // backpressure 1,0,0,1
        vecs[2] = '{1,   0,  40, -1, -1, 0,   0,  0};   // -1 / -4096
        vecs[3] = '{2,   0,  40, -1, -1, 0,   1,  1};   // starts in done cycle
        vecs[4] = '{0,   0,  40, 10, -1, 1,   0,  12};  // burst at idx 10
        vecs[5] = '{2,   1,  -1, -1, -1, 1,   0,  1};   // normal, overflow sticky
        vecs[6] = '{0,   0,  -1, -1,  5, 0,   0,  1};   // reset at idx 5
        vecs[7] = '{2,   0,  40, -1, -1, 0,   0,  1};   // fresh burst after reset

        for (int i = 0; i < 8; i++) begin
            run_burst(i, vecs[i]);
            if (vecs[i].idle > 0) check_idle(vecs[i].idle);
        end

`ifdef QR_COLLECT_LATCNT_EN
        lv = '{0, 0, 40, -1, -1, 0, 1, 0};
        // start, then the burst 37 cycles later
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (36) @(negedge clk);
        run_burst(8, lv);
        chk("lat_37", lat_cnt, 37);
        check_idle(1);
        // start and trigger in the same cycle
        start = 1'b1;
        run_burst(9, lv);
        chk("lat_same_cycle", lat_cnt, 0);
        check_idle(1);
        // no burst: saturation
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (600) @(negedge clk);
        chk("lat_saturate", lat_cnt, 511);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/qr_result_collector.md
Name: qr_result_collector

Overview:
- Receiving end of the QR_CORDIC output bus.
- Captures the 8-row x 4-element burst that QR_CORDIC emits after raising out_valid, and buffers it in an internal 8x52-bit row store.
- Drains the buffer element-by-element over a 13-bit valid/ready interface to downstream logic (result RAM, host port).
- Replaces the bench-side row checking with synthesizable logic.

Parameters:
- W, 13, element width (signed fixed-point)
- COLS, 4, elements per row; row bus width = W*COLS
- ROWS, 8, rows per burst

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  connects to QR_CORDIC out_valid; high in the cycle the first row is presented
- in_row  in  W*COLS  connects to QR_CORDIC out; element j occupies bits [W*j+W-1 : W*j]
- elem_valid  out  1  element available on elem_data
- elem_ready  in  1  downstream accepts element when high together with elem_valid
- elem_data  out  W  current element
- elem_idx  out  5  index of current element = COLS*row + col
- busy  out  1  high in CAPTURE or DRAIN
- done  out  1  one-cycle pulse after the last element is accepted
- overflow  out  1  sticky; a burst started while the previous one was still draining

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - elem_valid, done, overflow, busy = 0.
  - elem_data, elem_idx = 0.
  - Row/element counters = 0.
  - Buffer contents are don't-care.
- States: IDLE, CAPTURE, DRAIN.
- IDLE:
  - in_valid=1 → write in_row to buffer row 0, row_cnt=1, go to CAPTURE.
  - Otherwise stay in IDLE.
- CAPTURE:
  - Write in_row to buffer[row_cnt] every cycle, regardless of in_valid; the burst is exactly ROWS consecutive cycles.
  - Once row ROWS-1 is written, go to DRAIN with idx=0.
  - Capture occupies exactly ROWS cycles.
- DRAIN:
  - elem_valid=1; elem_data = buffer[idx/COLS][idx%COLS]; elem_idx=idx.
  - Both are registered. The first elem_valid is in the cycle after the last row is written.
  - elem_valid=1 and elem_ready=1 → idx increments, next element appears in the following cycle.
  - Throughput is one element per cycle with elem_ready held high.
  - elem_valid=1 and elem_ready=0 → elem_data and elem_idx held stable.
  - Accept of idx=ROWS*COLS-1 → elem_valid=0 next cycle, done=1 for exactly one cycle, return to IDLE.
- Minimum burst-to-done time: ROWS + ROWS*COLS + 1 cycles (41 at defaults).
- busy = (state != IDLE).
- Boundaries:
  - in_valid during CAPTURE: ignored as a trigger; the row is still captured.
  - in_valid during DRAIN: overflow set and held; the burst data is dropped; the drain continues unaffected. overflow is cleared only by rst.
  - in_valid in the same cycle done pulses: state is already IDLE → treated as a new burst start.
  - in_valid rising during the done cycle's transition: IDLE is entered on that edge, so in_valid is sampled on the next edge.
  - rst mid-CAPTURE or mid-DRAIN: immediate return to IDLE, all outputs take their reset values, and the partial burst is discarded.
- No arithmetic on data: elements pass through bit-exact as signed W-bit values.

Optional Feature:
- Macro: QR_COLLECT_LATCNT_EN.
- Defined:
  - Adds input start (1 bit) and output lat_cnt (9 bits).
  - start=1 clears lat_cnt to 0 and arms the counter.
  - While armed, lat_cnt increments by 1 per cycle, saturating at 511.
  - On the IDLE→CAPTURE transition the counter freezes, holding the cycle count from start to burst arrival.
  - Reset value 0.
  - start and the burst trigger in the same cycle → lat_cnt=0, frozen.
- Not defined: ports absent; no counter logic.

Test Plan:
- Single burst, elem_ready held 1: rows r=0..7 with element j value = 16*r + j (row 0 = 0,1,2,3; row 7 = 112..115) → elem_idx 0..31 on consecutive cycles, elem_data = idx + 12*(idx/4); first elem_valid 1 cycle after row 7; done pulses 41 cycles after in_valid.
- Backpressure: elem_ready toggles 1,0,0,1 repeating → elem_data/elem_idx stable during stalls, no element skipped or duplicated, all 32 values received in order.
- Negative data: rows filled with 13'h1FFF (-1) and 13'h1000 (-4096) alternating → identical bit patterns out, no sign corruption.
- Overflow: second in_valid pulse at drain idx=10 → overflow=1 and stays 1, first burst drains intact, no second drain; a third burst after done is captured normally with overflow still 1.
- Reset mid-drain: assert rst at idx=5 → elem_valid=0, busy=0, done=0, overflow=0 immediately; a following burst drains from idx 0 with the new data.
- With QR_COLLECT_LATCNT_EN: start pulse, burst arrives 37 cycles later → lat_cnt=37 and held through drain; no burst within 600 cycles → lat_cnt=511.
